spi_slave: RTL and testbench

- SPI slave (target) that answers the team's spi_master on the same 4-wire link.
- Samples sclk, cs_n and mosi from the external master into the system clock domain.
- Shifts out a parallel word on miso while shifting in a word from mosi.
- Presents the received word to local logic with a one-cycle valid strobe. Local logic supplies the next transmit word through a load/ready handshake.

---
 rtl/spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples sclk/cs_n/mosi in the clk domain, shifts a buffered word out on miso
// while assembling the received word. Define SPI_SLAVE_STATUS_EN to add sticky tx_underrun/rx_abort flags.
module spi_slave #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic             status_clr,
  output logic             tx_underrun,
  output logic             rx_abort
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int FIRST = LSB_FIRST ? 0 : WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, next_state;

  logic sclk_meta, sclk_sync, sclk_hist;
  logic cs_meta, cs_sync, cs_hist;
  logic mosi_meta, mosi_sync;

  logic [WIDTH-1:0] shift_in, shift_out, tx_buf;
  logic [WIDTH-1:0] in_next, out_next, load_word;
  logic [CNT_W-1:0] bit_cnt;
  logic             buf_full;

  logic rise, fall, cs_fall;
  logic word_start, word_done, shift_en, drive_next, go_idle, abort_evt, load_accept;

  // Two flops per input against metastability, plus a history flop so edges are seen for one cycle.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_hist <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_hist   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      cs_meta   <= cs_n;
      cs_sync   <= cs_meta;
      cs_hist   <= cs_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign rise    = sclk_sync & ~sclk_hist;
  assign fall    = ~sclk_sync & sclk_hist;
  assign cs_fall = ~cs_sync & cs_hist;

  assign in_next   = LSB_FIRST ? {mosi_sync, shift_in[WIDTH-1:1]} : {shift_in[WIDTH-2:0], mosi_sync};
  assign out_next  = LSB_FIRST ? (shift_out >> 1) : (shift_out << 1);
  assign load_word = buf_full ? tx_buf : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    word_start = 1'b0;
    word_done  = 1'b0;
    shift_en   = 1'b0;
    drive_next = 1'b0;
    go_idle    = 1'b0;
    abort_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state = ACTIVE;
          word_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (rise) begin
          shift_en  = 1'b1;
          word_done = (bit_cnt == LAST_BIT);
        end
        if (cs_sync) begin
          // A last-bit rise coinciding with deselect still delivers its word.
          next_state = IDLE;
          go_idle    = 1'b1;
          abort_evt  = !word_done && (bit_cnt != '0 || rise);
        end else begin
          word_start = word_done;
          // bit_cnt==0 here means the reload already put bit 0 of the next word on miso.
          drive_next = fall && (bit_cnt != '0);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A load arriving together with a reload is kept: the reload takes the old contents.
  assign load_accept = tx_load && (!buf_full || word_start);
  assign tx_ready    = ~buf_full;
  assign busy        = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_in  <= '0;
      shift_out <= '0;
      bit_cnt   <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_buf    <= '0;
      buf_full  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (shift_en) begin
        shift_in <= in_next;
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) begin
        rx_data  <= in_next;
        rx_valid <= 1'b1;
      end
      if (word_start) begin
        shift_out <= load_word;
        miso      <= load_word[FIRST];
      end else if (drive_next) begin
        shift_out <= out_next;
        miso      <= out_next[FIRST];
      end
      if (go_idle) begin
        shift_in  <= '0;
        shift_out <= '0;
        bit_cnt   <= '0;
        miso      <= 1'b0;
      end
      if (load_accept) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end else if (word_start) begin
        buf_full <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  // Sticky flags; a set event in the same cycle as status_clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_underrun <= 1'b0;
      rx_abort    <= 1'b0;
    end else begin
      if (word_start && !buf_full) tx_underrun <= 1'b1;
      else if (status_clr)         tx_underrun <= 1'b0;
      if (abort_evt)               rx_abort <= 1'b1;
      else if (status_clr)         rx_abort <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: an 8-bit LSB-first instance and a 16-bit MSB-first instance,
// driven by a mode-0 master model with received words scoreboarded through queues.
module tb_spi_slave;

  logic clk, rst;
  logic sclk, mosi, cs_n8, cs_n16;

  logic        miso8, tx_load8, tx_ready8, rx_valid8, busy8;
  logic [7:0]  tx_data8, rx_data8;
  logic        miso16, tx_load16, tx_ready16, rx_valid16, busy16;
  logic [15:0] tx_data16, rx_data16;
`ifdef SPI_SLAVE_STATUS_EN
  logic status_clr, tx_underrun8, rx_abort8, tx_underrun16, rx_abort16;
`endif

  int checks = 0;
  int errors = 0;
  int rx_count8 = 0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];

  spi_slave #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n8), .mosi(mosi), .miso(miso8),
    .tx_data(tx_data8), .tx_load(tx_load8), .tx_ready(tx_ready8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(status_clr), .tx_underrun(tx_underrun8), .rx_abort(rx_abort8)
`endif
  );

  spi_slave #(.WIDTH(16), .LSB_FIRST(1'b0)) dut16 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n16), .mosi(mosi), .miso(miso16),
    .tx_data(tx_data16), .tx_load(tx_load16), .tx_ready(tx_ready16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(status_clr), .tx_underrun(tx_underrun16), .rx_abort(rx_abort16)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the next queued word.
  always @(negedge clk) begin
    if (rst && rx_valid8) begin
      rx_count8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rx8_unexpected: observed %0h expected no word", rx_data8);
      end else check("rx8_word", rx_data8, q8.pop_front());
    end
    if (rst && rx_valid16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rx16_unexpected: observed %0h expected no word", rx_data16);
      end else check("rx16_word", rx_data16, q16.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic load8(input logic [7:0] d);
    @(negedge clk);
    tx_data8 = d;
    tx_load8 = 1'b1;
    @(negedge clk);
    tx_load8 = 1'b0;
  endtask

  task automatic load16(input logic [15:0] d);
    @(negedge clk);
    tx_data16 = d;
    tx_load16 = 1'b1;
    @(negedge clk);
    tx_load16 = 1'b0;
  endtask

  // Mode-0 master, sclk = clk/8: mosi set while sclk low, miso sampled just before each rise.
  task automatic send(input logic [15:0] mo, input logic [15:0] mi, input int n, input int nsend,
                      input bit lsb, input bit sel16, input bit chk);
    for (int i = 0; i < nsend; i++) begin
      int idx;
      idx = lsb ? i : n - 1 - i;
      mosi = mo[idx];
      #40;
      if (chk) check(sel16 ? "miso16_bit" : "miso8_bit", sel16 ? miso16 : miso8, mi[idx]);
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic select(input bit sel16);
    if (sel16) cs_n16 = 1'b0;
    else       cs_n8  = 1'b0;
    #80;
  endtask

  task automatic deselect();
    #40;
    cs_n8  = 1'b1;
    cs_n16 = 1'b1;
    #100;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n8 = 1'b1; cs_n16 = 1'b1;
    tx_data8 = '0; tx_load8 = 1'b0; tx_data16 = '0; tx_load16 = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    status_clr = 1'b0;
`endif
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", miso8, 0);
    check("rst_rx_data", rx_data8, 0);
    check("rst_rx_valid", rx_valid8, 0);
    check("rst_tx_ready", tx_ready8, 1);
    check("rst_busy", busy8, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single word, tx A5 out while 3C comes in
    load8(8'hA5);
    check("t1_tx_ready_full", tx_ready8, 0);
    q8.push_back(8'h3C);
    select(1'b0);
    check("t1_busy", busy8, 1);
    check("t1_tx_ready_refill", tx_ready8, 1);
    send(16'h003C, 16'h00A5, 8, 8, 1'b1, 1'b0, 1'b1);
    deselect();
    check("t1_rx_data", rx_data8, 8'h3C);
    check("t1_rx_count", rx_count8, 1);
    check("t1_busy_idle", busy8, 0);

    // 2: back-to-back words, second tx word loaded mid-first-word
    load8(8'h01);
    q8.push_back(8'h96);
    q8.push_back(8'h5C);
    select(1'b0);
    fork
      send(16'h0096, 16'h0001, 8, 8, 1'b1, 1'b0, 1'b1);
      begin
        #200;
        load8(8'h80);
      end
    join
    send(16'h005C, 16'h0080, 8, 8, 1'b1, 1'b0, 1'b1);
    deselect();
    check("t2_rx_data", rx_data8, 8'h5C);
    check("t2_rx_count", rx_count8, 3);

`ifdef SPI_SLAVE_STATUS_EN
    @(negedge clk) status_clr = 1'b1;
    @(negedge clk) status_clr = 1'b0;
    check("t3_underrun_clr", tx_underrun8, 0);
`endif
    // 3: no tx_load, miso must stay zero
    q8.push_back(8'hC3);
    select(1'b0);
    send(16'h00C3, 16'h0000, 8, 8, 1'b1, 1'b0, 1'b1);
    deselect();
    check("t3_rx_data", rx_data8, 8'hC3);
`ifdef SPI_SLAVE_STATUS_EN
    check("t3_underrun_set", tx_underrun8, 1);
    @(negedge clk) status_clr = 1'b1;
    @(negedge clk) status_clr = 1'b0;
    check("t3_underrun_cleared", tx_underrun8, 0);
`endif

    // 4: abort after 5 rises, then a full FF word
    select(1'b0);
    send(16'h00FF, 16'h0000, 8, 5, 1'b1, 1'b0, 1'b0);
    deselect();
    check("t4_rx_hold", rx_data8, 8'hC3);
    check("t4_rx_count", rx_count8, 4);
    check("t4_busy", busy8, 0);
    check("t4_miso", miso8, 0);
`ifdef SPI_SLAVE_STATUS_EN
    check("t4_rx_abort", rx_abort8, 1);
`endif
    q8.push_back(8'hFF);
    select(1'b0);
    send(16'h00FF, 16'h0000, 8, 8, 1'b1, 1'b0, 1'b1);
    deselect();
    check("t4_rx_ff", rx_data8, 8'hFF);

    // 5: asynchronous reset mid-word
    load8(8'h33);
    select(1'b0);
    send(16'h0077, 16'h0033, 8, 3, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check("t5_rst_miso", miso8, 0);
    check("t5_rst_rx_data", rx_data8, 0);
    check("t5_rst_rx_valid", rx_valid8, 0);
    check("t5_rst_tx_ready", tx_ready8, 1);
    check("t5_rst_busy", busy8, 0);
    cs_n8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    q8.push_back(8'h5A);
    select(1'b0);
    send(16'h005A, 16'h0000, 8, 8, 1'b1, 1'b0, 1'b1);
    deselect();
    check("t5_rx_data", rx_data8, 8'h5A);

    // 6: 16-bit MSB-first instance
    load16(16'hC3A5);
    q16.push_back(16'h8001);
    select(1'b1);
    send(16'h8001, 16'hC3A5, 16, 16, 1'b0, 1'b1, 1'b1);
    deselect();
    check("t6_rx_data", rx_data16, 16'h8001);
    check("t6_busy", busy16, 0);

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q16_drained", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
